// File: rtl/shift_exec_pipe.sv
// shift_exec_pipe: two-stage RV32I SLL/SRL/SRA unit with a valid/ready handshake on each side.
// SLL bit-reverses its operand so one right-shift network serves all three ops.
module shift_exec_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [4:0]      i_shamt,
    input  logic [TAGW-1:0] i_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [TAGW-1:0] o_rd,
    output logic            o_illegal
);
    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_part_q, s1_part_d;
    logic [1:0]      s1_sh_q, s1_sh_d;
    logic            s1_fill_q, s1_fill_d;
    logic            s1_rev_q, s1_rev_d;
    logic [TAGW-1:0] s1_rd_q, s1_rd_d;
    logic            s1_ill_q, s1_ill_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_res_q, out_res_d;
    logic [TAGW-1:0] out_rd_q, out_rd_d;
    logic            out_ill_q, out_ill_d;
    logic            stage2_adv, accept, ill, fill;
    logic [XLEN-1:0] a_rev, x, p1, p2, p4, y8, y16, y16_rev;

    assign stage2_adv = !out_valid_q || i_ready;
    assign o_ready    = !i_flush && (!s1_valid_q || stage2_adv);
    assign accept     = i_valid && o_ready;
    assign a_rev      = {<<{i_a}};
    assign y16_rev    = {<<{y16}};

    always_comb begin
        ill  = i_op == 2'b10;
        // Reserved ops feed zero with zero fill so the result comes out as 0.
        fill = (i_op == 2'b11) && i_a[XLEN-1];
        x    = ill ? '0 : (i_op == 2'b00) ? a_rev : i_a;
        p1   = i_shamt[0] ? {fill, x[XLEN-1:1]} : x;
        p2   = i_shamt[1] ? {{2{fill}}, p1[XLEN-1:2]} : p1;
        p4   = i_shamt[2] ? {{4{fill}}, p2[XLEN-1:4]} : p2;
        y8   = s1_sh_q[0] ? {{8{s1_fill_q}}, s1_part_q[XLEN-1:8]} : s1_part_q;
        y16  = s1_sh_q[1] ? {{16{s1_fill_q}}, y8[XLEN-1:16]} : y8;
        s1_valid_d  = i_flush ? 1'b0 : accept ? 1'b1 : stage2_adv ? 1'b0 : s1_valid_q;
        s1_part_d   = accept ? p4 : s1_part_q;
        s1_sh_d     = accept ? i_shamt[4:3] : s1_sh_q;
        s1_fill_d   = accept ? fill : s1_fill_q;
        s1_rev_d    = accept ? (i_op == 2'b00) : s1_rev_q;
        s1_rd_d     = accept ? i_rd : s1_rd_q;
        s1_ill_d    = accept ? ill : s1_ill_q;
        out_valid_d = i_flush ? 1'b0 : stage2_adv ? s1_valid_q : out_valid_q;
        out_res_d   = (stage2_adv && s1_valid_q) ? (s1_rev_q ? y16_rev : y16) : out_res_q;
        out_rd_d    = (stage2_adv && s1_valid_q) ? s1_rd_q : out_rd_q;
        out_ill_d   = (stage2_adv && s1_valid_q) ? s1_ill_q : out_ill_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_part_q   <= '0;
            s1_sh_q     <= '0;
            s1_fill_q   <= 1'b0;
            s1_rev_q    <= 1'b0;
            s1_rd_q     <= '0;
            s1_ill_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_rd_q    <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_part_q   <= s1_part_d;
            s1_sh_q     <= s1_sh_d;
            s1_fill_q   <= s1_fill_d;
            s1_rev_q    <= s1_rev_d;
            s1_rd_q     <= s1_rd_d;
            s1_ill_q    <= s1_ill_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_rd_q    <= out_rd_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_result  = out_res_q;
    assign o_rd      = out_rd_q;
    assign o_illegal = out_ill_q;
endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb_shift_exec_pipe: directed checks of shift_exec_pipe latency, backpressure, flush, reset and edge cases.
module tb_shift_exec_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_a = '0;
    logic [4:0]  i_shamt = '0;
    logic [4:0]  i_rd = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_illegal;
    int          total = 0;
    int          bad = 0;

    shift_exec_pipe #(.XLEN(32), .TAGW(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_op(i_op), .i_a(i_a), .i_shamt(i_shamt), .i_rd(i_rd),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rd(o_rd),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [4:0] rd);
        i_valid = v; i_op = op; i_a = a; i_shamt = sh; i_rd = rd;
    endtask

    task automatic out_is(input string tag, input logic [31:0] res, input logic [4:0] rd,
                          input logic ill);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_result"}, o_result, res);
        chk({tag, "_rd"}, 32'(o_rd), 32'(rd));
        chk({tag, "_illegal"}, 32'(o_illegal), 32'(ill));
    endtask

    logic [31:0] stream_exp [8];

    initial begin
        cyc(); cyc();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        // directed ops, 2-edge latency
        put(1, 2'b11, 32'h8000_00F0, 5'd4, 5'd1);
        cyc();
        chk("lat_s1_only", 32'(o_valid), 32'd0);
        put(1, 2'b01, 32'h8000_00F0, 5'd4, 5'd2);
        cyc();
        out_is("sra4", 32'hF800_000F, 5'd1, 1'b0);
        put(1, 2'b00, 32'h0000_0001, 5'd31, 5'd3);
        cyc();
        out_is("srl4", 32'h0800_000F, 5'd2, 1'b0);
        put(1, 2'b00, 32'h1234_5678, 5'd0, 5'd4);
        cyc();
        out_is("sll31", 32'h8000_0000, 5'd3, 1'b0);
        put(1, 2'b01, 32'h9ABC_DEF0, 5'd0, 5'd5);
        cyc();
        out_is("sll0", 32'h1234_5678, 5'd4, 1'b0);
        put(1, 2'b11, 32'h8000_0001, 5'd0, 5'd6);
        cyc();
        out_is("srl0", 32'h9ABC_DEF0, 5'd5, 1'b0);
        put(1, 2'b10, 32'hFFFF_FFFF, 5'd3, 5'd7);
        cyc();
        out_is("sra0", 32'h8000_0001, 5'd6, 1'b0);
        put(1, 2'b11, 32'h8000_0000, 5'd31, 5'd8);
        cyc();
        out_is("reserved", 32'h0000_0000, 5'd7, 1'b1);
        put(1, 2'b01, 32'h8765_4321, 5'd31, 5'd9);
        cyc();
        out_is("sra31", 32'hFFFF_FFFF, 5'd8, 1'b0);
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        out_is("srl31", 32'h0000_0001, 5'd9, 1'b0);
        cyc();
        chk("drained", 32'(o_valid), 32'd0);
        // back-to-back streaming of 8 ops
        for (int i = 0; i < 8; i++) begin
            stream_exp[i] = 32'h8000_0000 >> (3 * i);
            put(1, 2'b01, 32'h8000_0000, 5'(3 * i), 5'(10 + i));
            cyc();
            if (i > 0) out_is($sformatf("stream%0d", i - 1), stream_exp[i - 1], 5'(9 + i), 1'b0);
        end
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        out_is("stream7", stream_exp[7], 5'd17, 1'b0);
        cyc();
        chk("stream_end", 32'(o_valid), 32'd0);
        // backpressure
        i_ready = 1'b0;
        put(1, 2'b01, 32'hF000_0000, 5'd4, 5'd20);
        #1;
        chk("bp_ready_a", 32'(o_ready), 32'd1);
        cyc();
        put(1, 2'b00, 32'h0000_0001, 5'd1, 5'd21);
        #1;
        chk("bp_ready_b", 32'(o_ready), 32'd1);
        cyc();
        put(1, 2'b11, 32'h8000_0000, 5'd1, 5'd22);
        #1;
        chk("bp_ready_c", 32'(o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            out_is($sformatf("bp_hold%0d", i), 32'h0F00_0000, 5'd20, 1'b0);
            chk($sformatf("bp_ready_hold%0d", i), 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_ready_rel", 32'(o_ready), 32'd1);
        cyc();
        out_is("bp_b", 32'h0000_0002, 5'd21, 1'b0);
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        out_is("bp_c", 32'hC000_0000, 5'd22, 1'b0);
        cyc();
        chk("bp_end", 32'(o_valid), 32'd0);
        // flush with both stages occupied
        put(1, 2'b01, 32'hFFFF_0000, 5'd8, 5'd30);
        cyc();
        put(1, 2'b01, 32'hFFFF_0000, 5'd16, 5'd31);
        cyc();
        out_is("pre_flush", 32'h00FF_FF00, 5'd30, 1'b0);
        i_flush = 1'b1;
        put(1, 2'b11, 32'h8000_0000, 5'd4, 5'd1);
        #1;
        chk("flush_ready", 32'(o_ready), 32'd0);
        cyc();
        chk("flush_valid", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        put(1, 2'b00, 32'h0000_000F, 5'd4, 5'd2);
        cyc();
        chk("flush_killed", 32'(o_valid), 32'd0);
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        out_is("post_flush", 32'h0000_00F0, 5'd2, 1'b0);
        cyc();
        chk("post_flush_end", 32'(o_valid), 32'd0);
        // async reset with both stages occupied
        put(1, 2'b01, 32'hAAAA_AAAA, 5'd1, 5'd11);
        cyc();
        put(1, 2'b01, 32'h5555_5555, 5'd1, 5'd12);
        cyc();
        out_is("pre_rst", 32'h5555_5555, 5'd11, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_result", o_result, 32'd0);
        chk("arst_rd", 32'(o_rd), 32'd0);
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        i_rst_n = 1'b1;
        put(1, 2'b11, 32'hF000_0000, 5'd28, 5'd13);
        cyc();
        chk("post_rst_s1", 32'(o_valid), 32'd0);
        put(0, 2'b00, 32'h0, 5'd0, 5'd0);
        cyc();
        out_is("post_rst", 32'hFFFF_FFFF, 5'd13, 1'b0);
        cyc();
        chk("post_rst_end", 32'(o_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
